// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES types, constants and helpers used by the key-expansion engine
// and its sub-modules.
//   aes_word_t      : one 32-bit AES word
//   aes_block_t     : one 128-bit block / round key, byte 0 in bits [127:120]
//   AES128_NUM_RK   : number of AES-128 round keys (indices 0..10)
//   aes_kx_state_e  : key-expansion FSM states
//   xtime()         : GF(2^8) multiply-by-x, used to step the round constant
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    localparam int AES128_NUM_RK = 11;

    typedef enum logic {
        IDLE,
        RUN
    } aes_kx_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// -----------------------------------------------------------------------------
// aes_key_expand_if
// Load/handshake bundle between a key source / round-key consumer (master)
// and the key-expansion engine (slave).
//   start    : master -> slave, request a new expansion
//   key      : master -> slave, cipher key sampled with start
//   rk_ready : master -> slave, consumer accepts the current round key
//   busy     : slave -> master, expansion in progress
//   rk_valid : slave -> master, rk/rk_idx hold a valid round key
//   rk       : slave -> master, current round key
//   rk_idx   : slave -> master, index of rk (0..10)
//   done     : slave -> master, one-cycle pulse after round key 10 is taken
// -----------------------------------------------------------------------------
interface aes_key_expand_if;
    import aes_pkg::*;

    logic       start;
    aes_block_t key;
    logic       rk_ready;
    logic       busy;
    logic       rk_valid;
    aes_block_t rk;
    logic [3:0] rk_idx;
    logic       done;

    modport master (
        output start, key, rk_ready,
        input  busy, rk_valid, rk, rk_idx, done
    );

    modport slave (
        input  start, key, rk_ready,
        output busy, rk_valid, rk, rk_idx, done
    );

endinterface

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box (SubBytes on one byte).
//   value  : input byte
//   result : substituted byte
// -----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);

    // Table entry 0 sits in the top byte, so entry v lives at bit (255-v)*8.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign result = SBOX_FLAT[{~value, 3'b000} +: 8];

endmodule

// File: rtl/aes_sub_word.sv
// -----------------------------------------------------------------------------
// aes_sub_word
// SubWord: applies the AES S-box to each byte of a 32-bit word, keeping byte
// positions. Purely combinational.
//   word : input word
//   sub  : substituted word
// -----------------------------------------------------------------------------
module aes_sub_word
    import aes_pkg::*;
(
    input  aes_word_t word,
    output aes_word_t sub
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .value  (word[8*i +: 8]),
            .result (sub[8*i +: 8])
        );
    end

endmodule

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
// Iterative AES-128 key schedule. Captures a cipher key on start and presents
// round keys 0..10 in order, advancing one round per accepted handshake.
//   ZEROIZE : when 1, rk is cleared on every return to IDLE
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   kx      : aes_key_expand_if.slave (start/key in, rk_valid/rk/rk_idx out,
//             rk_ready in, busy/done out)
// -----------------------------------------------------------------------------
module aes_key_expand
    import aes_pkg::*;
#(
    parameter bit ZEROIZE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    aes_key_expand_if.slave    kx
);

    aes_kx_state_e state, next_state;

    aes_block_t rk_q;
    logic [3:0] idx_q;
    logic [7:0] rcon_q;
    logic       done_q;

    logic busy, valid;
    logic handshake, last;

    aes_word_t  w0, w1, w2, w3;
    aes_word_t  rot, sub, t;
    aes_word_t  n0, n1, n2, n3;
    aes_block_t next_rk;

    assign handshake = valid && kx.rk_ready;
    assign last      = (idx_q == 4'(AES128_NUM_RK - 1));

    // ---------------------------------------------------------------- next key
    assign {w0, w1, w2, w3} = rk_q;
    assign rot = {w3[23:0], w3[31:24]};

    aes_sub_word u_sub_word (
        .word (rot),
        .sub  (sub)
    );

    assign t  = sub ^ {rcon_q, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on paths that do not assign next_state.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (kx.start)         next_state = RUN;
            RUN:  if (handshake && last) next_state = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == RUN);
        valid = (state == RUN);
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_q   <= '0;
            idx_q  <= '0;
            rcon_q <= 8'h01;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    // start is only honoured here; in RUN it and key are ignored.
                    if (kx.start) begin
                        rk_q   <= kx.key;
                        idx_q  <= '0;
                        rcon_q <= 8'h01;
                    end
                end
                RUN: begin
                    // Without a handshake everything holds, keeping rk/rk_idx
                    // stable under backpressure.
                    if (handshake) begin
                        if (last) begin
                            done_q <= 1'b1;
                            idx_q  <= '0;
                            if (ZEROIZE) rk_q <= '0;
                        end else begin
                            rk_q   <= next_rk;
                            idx_q  <= idx_q + 4'd1;
                            rcon_q <= xtime(rcon_q);
                        end
                    end
                end
            endcase
        end
    end

    assign kx.busy     = busy;
    assign kx.rk_valid = valid;
    assign kx.rk       = rk_q;
    assign kx.rk_idx   = idx_q;
    assign kx.done     = done_q;

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key-schedule engine. Loads a 128-bit cipher key on `start` and emits the 11 round keys (indices 0..10) in order, one per accepted handshake. SubWord is computed with four instances of the existing byte S-box. Sits between key load and the round datapath, which consumes one round key per round.

## Interface
- `ZEROIZE`, default 1: when 1, `rk` is cleared to 0 on every return to IDLE. When 0, `rk` holds its last value.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a new expansion; sampled only in IDLE.
- `key` input 128: cipher key, sampled when `start` is accepted; `key[127:120]` is byte 0 (MSB of w0).
- `busy` output 1: high in RUN.
- `rk_valid` output 1: round key on `rk` is valid.
- `rk_ready` input 1: consumer accepts `rk` when `rk_valid && rk_ready`.
- `rk` output 128: current round key, same byte order as `key`.
- `rk_idx` output 4: index of `rk`, 0..10.
- `done` output 1: one-cycle pulse after round key 10 is accepted.

## Operation
- FSM states: IDLE, RUN.
- **IDLE**
  - If `start`: `rk <= key`, `rk_idx <= 0`, `rcon <= 8'h01`, go to RUN.
  - Otherwise hold.
- **RUN**
  - `rk_valid = 1`.
  - On handshake with `rk_idx < 10`:
    - `rk <= next_rk`, `rk_idx <= rk_idx + 1`.
    - `rcon <= xtime(rcon)`, i.e. `{rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0)`.
  - On handshake with `rk_idx == 10`: go to IDLE, `done <= 1` for one cycle, `rk_idx <= 0`, `rk` cleared if `ZEROIZE`.
  - Without handshake: all registers hold. `rk` and `rk_idx` must be stable while `rk_valid && !rk_ready`.
- **`next_rk`** is combinational from the registered `rk` = {w0,w1,w2,w3}:
  - `t = SubWord(RotWord(w3)) ^ {rcon,24'h0}`; `RotWord({a,b,c,d}) = {b,c,d,a}`.
  - `n0 = w0^t`, `n1 = w1^n0`, `n2 = w2^n1`, `n3 = w3^n2`.
  - `next_rk = {n0,n1,n2,n3}`.
- Rcon sequence over indices 1..10: 01,02,04,08,10,20,40,80,1b,36.
- `start` in RUN is ignored; `key` changes in RUN are ignored.
- `start` in the same cycle as the `done` pulse (already IDLE) is accepted normally.
- All arithmetic is GF(2) XOR; no carries or widening.

## Timing
- Reset values: state IDLE, `busy` 0, `rk_valid` 0, `rk` 0, `rk_idx` 0, `done` 0, `rcon` 8'h01.
- Reset mid-RUN aborts immediately. Next cycle all outputs are at reset values; no `done` pulse.
- `start` accepted at edge N: `rk_valid`=1, `rk_idx`=0, `rk`=`key` from edge N.
- With `rk_ready` held high, one round key per cycle: indices 0..10 in 11 consecutive cycles.
- `done` is high in the cycle after the final handshake, with `busy`=0 and `rk_valid`=0.
- Minimum start-to-start period: 12 cycles.
- Critical path: `rk` register → S-box → 4-deep XOR chain → `rk` register. No pipelining.

## Structure
- Shared package `aes_pkg`:
  - `aes_word_t` (logic [31:0]) and `aes_block_t` (logic [127:0]) typedefs.
  - `AES128_NUM_RK` = 11.
  - `xtime` function.
  - FSM state enum `aes_kx_state_e` {IDLE, RUN}.
- One sub-module `aes_sub_word`: 32-bit in/out, four `aes_sbox` instances, purely combinational.
- Top module holds FSM, `rk`/`rk_idx`/`rcon` registers and the XOR chain.

## Test plan
- **FIPS-197 key, `rk_ready`=1**
  - Stimulus: `key` 2b7e151628aed2a6abf7158809cf4f3c, `start`.
  - idx0 = key.
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` one cycle after idx10.
- **All-zero key**
  - idx1 = 62636363626363636263636362636363.
  - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- **Random backpressure on `rk_ready` (~50%)**
  - Same 11 keys in order; `rk`/`rk_idx` stable while stalled.
  - Exactly one `done`.
- **Reset mid-run**
  - Stimulus: assert `rst` at idx 5.
  - Next cycle all outputs at reset values; no `done`.
  - A fresh `start` yields idx0 = new key.
- **Ignored start**
  - Stimulus: pulse `start` with a different `key` at idx 3.
  - Sequence unaffected; `busy` stays 1.
- **Back-to-back and ZEROIZE**
  - Stimulus: `start` in the `done` cycle.
  - Second expansion correct.
  - With `ZEROIZE`=1, `rk` = 0 in the IDLE cycle between runs.
